muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port op_valid, input, 1: EX stage presents a HI/LO-writing instruction this cycle.
REQ-005 SHALL have port op_code, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-006 SHALL have port rs_val, input, 32: rs operand (dividend or multiplicand; MTHI/MTLO source).
REQ-007 SHALL have port rt_val, input, 32: rt operand (divisor or multiplier).
REQ-008 SHALL have port rd_req, input, 1: EX holds MFHI or MFLO this cycle.
REQ-009 SHALL have port flush, input, 1: EX instruction is squashed this cycle.
REQ-010 SHALL have port busy, output, 1: iterative operation in progress.
REQ-011 SHALL have port stall, output, 1: combinational pipeline hold request.
REQ-012 SHALL have port done, output, 1: single-cycle pulse in the HI/LO write cycle of MULT/MULTU/DIV/DIVU.
REQ-013 SHALL have ports hi_out and lo_out, output, 32 each: architectural HI and LO registers.

Function
REQ-014 SHALL implement states IDLE, RUN, FIX.
REQ-015 Accept = op_valid & ~flush & ~stall & state IDLE & op_code 000..011; the accepting cycle is N.
REQ-016 On accept, SHALL latch op type, |rs|, |rt| (magnitude for signed ops, raw for unsigned), result signs, zero-divisor flag, iteration count 0; next state RUN.
REQ-017 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, cycles N+1..N+32; after count 31, next state FIX.
REQ-018 FIX (cycle N+33) SHALL apply sign correction, write HI/LO at end of cycle, assert done; next state IDLE.
REQ-019 New HI/LO SHALL be visible on hi_out/lo_out from cycle N+34; total latency 34 cycles from accept.
REQ-020 busy SHALL be 1 exactly in RUN and FIX (N+1..N+33).
REQ-021 stall SHALL equal busy & ((op_valid & ~flush) | rd_req); an op presented while busy is held, never dropped or queued.
REQ-022 MTHI/MTLO accepted in IDLE SHALL write hi_out/lo_out with rs_val at end of that cycle; no busy, no done.
REQ-023 Multiply: {HI,LO} = 64-bit product; signed result negated when operand signs differ.
REQ-024 Divide: LO = quotient, HI = remainder; signed quotient negated when signs differ; signed remainder takes dividend sign.
REQ-025 Divide by zero (DIV or DIVU): HI = original rs_val, LO = 32'hFFFFFFFF; same 34-cycle latency.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO = 0x80000000, HI = 0.
REQ-027 flush SHALL only block acceptance in its cycle; it SHALL NOT abort an operation already in RUN/FIX.
REQ-028 op_valid in IDLE with op_code 110/111 SHALL have no effect.
REQ-029 rd_req in IDLE SHALL never stall; hi_out/lo_out are the current register values.

Reset
REQ-030 reset SHALL force state IDLE, hi_out = 0, lo_out = 0, busy = 0, done = 0, count = 0 at the next edge.
REQ-031 reset during RUN/FIX SHALL abandon the operation: no HI/LO write, no done pulse.
REQ-032 reset SHALL take priority over accept in the same cycle.

Verification
REQ-033 MULT rs=0xFFFFFFFF rt=2 -> done at N+33; HI=0xFFFFFFFF, LO=0xFFFFFFFE at N+34; MULTU same operands -> HI=1, LO=0xFFFFFFFE.
REQ-034 DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=7 rt=0 -> HI=7, LO=0xFFFFFFFF.
REQ-035 MULTU issued at N, rd_req asserted at N+5 and held -> stall=1 for N+5..N+33, 0 at N+34, and hi_out holds the new product at N+34.
REQ-036 DIVU at N, second MULT held on op_valid from N+2 -> stall through N+33, second op accepted at N+34, its done at N+67.
REQ-037 MULT at N, reset asserted at N+10 -> busy=0, hi_out=lo_out=0 from N+11; no done pulse appears.
REQ-038 MTLO rs=0x1234 with flush=1 -> lo_out unchanged; repeated with flush=0 -> lo_out=0x1234 next cycle, busy stays 0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative HI/LO multiply/divide sequencer
// One shift-add or restoring shift-subtract step per cycle; sign fix-up in a final cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            rd_req,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t            state, state_next;
  logic [4:0]        count;
  logic              is_div, neg_q, neg_r, div_zero;
  logic [XLEN-1:0]   opnd_b, rs_orig;
  logic [2*XLEN-1:0] acc, mul_next, div_next, prod_fix;
  logic [XLEN:0]     add_sum, rem_shift, sub_diff;
  logic [XLEN-1:0]   rs_mag, rt_mag, quo_fix, rem_fix;
  logic              sgn_op, accept, move;

  assign busy   = (state != IDLE);
  assign stall  = busy & ((op_valid & ~flush) | rd_req);
  assign accept = op_valid & ~flush & ~stall & (state == IDLE) & ~op_code[2];
  assign move   = op_valid & ~flush & (state == IDLE) & op_code[2] & ~op_code[1];

  // Even op codes (MULT, DIV) are the signed flavours.
  assign sgn_op = ~op_code[0];
  assign rs_mag = (sgn_op & rs_val[XLEN-1]) ? -rs_val : rs_val;
  assign rt_mag = (sgn_op & rt_val[XLEN-1]) ? -rt_val : rt_val;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_b} : {(XLEN+1){1'b0}});
  assign mul_next  = {add_sum, acc[XLEN-1:1]};
  assign rem_shift = acc[2*XLEN-1:XLEN-1];
  assign sub_diff  = rem_shift - {1'b0, opnd_b};
  assign div_next  = sub_diff[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (count == 5'd31) state_next = FIX;
      FIX: begin
        state_next = IDLE;
        done       = ~reset;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 5'd0;
      hi_out   <= '0;
      lo_out   <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      rs_orig  <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (accept) begin
        is_div   <= op_code[1];
        neg_q    <= sgn_op & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
        neg_r    <= sgn_op & rs_val[XLEN-1];
        div_zero <= (rt_val == '0);
        rs_orig  <= rs_val;
        opnd_b   <= rt_mag;
        acc      <= {{XLEN{1'b0}}, rs_mag};
        count    <= 5'd0;
      end
      if (state == RUN) begin
        count <= count + 5'd1;
        acc   <= is_div ? div_next : mul_next;
      end
      if (state == FIX) begin
        count <= 5'd0;
        if (!is_div)      {hi_out, lo_out} <= prod_fix;
        else if (div_zero) begin
          hi_out <= rs_orig;
          lo_out <= '1;
        end else begin
          hi_out <= rem_fix;
          lo_out <= quo_fix;
        end
      end
      if (move) begin
        if (op_code[0]) lo_out <= rs_val;
        else            hi_out <= rs_val;
      end
    end
  end

endmodule
